// File: rtl/ofdm_sc_mapper_pkg.sv
// Shared OFDM constants, QAM levels and the bin-to-entry helper used by
// the subcarrier mapper.
package ofdm_pkg;

  localparam int unsigned NFFT_DEF  = 64;
  localparam int unsigned NDATA_DEF = 48;
  localparam int unsigned W_DEF     = 11;

  // 16-QAM amplitude levels, shared with the upstream mapper
  localparam int QAM_LVL_P1 = 2;
  localparam int QAM_LVL_P3 = 6;
  localparam int QAM_LVL_N1 = -2;
  localparam int QAM_LVL_N3 = -6;

  // Entry index width; data-subcarrier count is limited to 256
  localparam int unsigned ENTRY_W = 8;

  typedef struct packed {
    logic               is_data;
    logic [ENTRY_W-1:0] entry;
  } bin_map_t;

  // Bins 1..ndata/2 and the top ndata/2 bins carry data; the rest are nulls
  function automatic bin_map_t bin_to_entry(input int unsigned bin,
                                            input int unsigned nfft,
                                            input int unsigned ndata);
    bin_map_t m;
    m = '0;
    if (bin != 0 && bin <= ndata / 2) begin
      m.is_data = 1'b1;
      m.entry   = ENTRY_W'(bin - 1);
    end else if (bin >= nfft - ndata / 2 && bin < nfft) begin
      m.is_data = 1'b1;
      m.entry   = ENTRY_W'(bin - nfft + ndata);
    end
    return m;
  endfunction

endpackage

// File: rtl/ofdm_sc_mapper_pingpong_buf.sv
// Two-bank symbol buffer: fills banks in turn from the mapper stream,
// drops samples aimed at a full bank and raises a sticky overflow flag.
module sc_pingpong_buf
  import ofdm_pkg::*;
#(
  parameter int unsigned NDATA = NDATA_DEF,
  parameter int unsigned W     = W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                wr_valid,
  input  logic signed [W-1:0] wr_xr,
  input  logic signed [W-1:0] wr_xi,
  input  logic                wr_flush,
  input  logic                rd_bank,
  input  logic [ENTRY_W-1:0]  rd_addr,
  output logic signed [W-1:0] rd_xr_c,
  output logic signed [W-1:0] rd_xi_c,
  input  logic                free,
  input  logic                free_bank,
  output logic [1:0]          full,
  output logic                ovf
);

  localparam int unsigned ADDR_W = $clog2(NDATA);

  logic [2*W-1:0]    mem [2][NDATA];
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_cnt;
  logic              wr_en_c;
  logic              wr_last_c;

  // A flush wins over a sample in the same cycle
  always_comb begin
    wr_en_c   = wr_valid && !wr_flush && !full[wr_bank];
    wr_last_c = (wr_cnt == ADDR_W'(NDATA - 1));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      full    <= '0;
      ovf     <= 1'b0;
    end else begin
      if (wr_flush) begin
        wr_cnt <= '0;
      end else if (wr_en_c) begin
        if (wr_last_c) begin
          wr_cnt        <= '0;
          wr_bank       <= ~wr_bank;
          full[wr_bank] <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + ADDR_W'(1);
        end
      end else if (wr_valid) begin
        ovf <= 1'b1;
      end
      // Freeing only ever targets a full bank, never the one being completed
      if (free) begin
        full[free_bank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en_c) begin
      mem[wr_bank][wr_cnt] <= {wr_xr, wr_xi};
    end
  end

  always_comb begin
    rd_xr_c = '0;
    rd_xi_c = '0;
    if (rd_addr < ENTRY_W'(NDATA)) begin
      {rd_xr_c, rd_xi_c} = mem[rd_bank][ADDR_W'(rd_addr)];
    end
  end

endmodule

// File: rtl/ofdm_sc_mapper.sv
// OFDM subcarrier mapper: buffers one symbol of QAM points and streams all
// NFFT bins in natural order, nulling DC and guard bins.
module ofdm_sc_mapper
  import ofdm_pkg::*;
#(
  parameter int unsigned NFFT  = NFFT_DEF,
  parameter int unsigned NDATA = NDATA_DEF,
  parameter int unsigned W     = W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_xr,
  input  logic signed [W-1:0] in_xi,
  input  logic                sym_flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_xr,
  output logic signed [W-1:0] out_xi,
  output logic                out_sop,
  output logic                out_eop,
  output logic                ovf
);

  localparam int unsigned BIN_W = $clog2(NFFT);

  logic                rd_bank;
  logic [BIN_W-1:0]    rd_bin;
  logic [1:0]          full;
  logic signed [W-1:0] rd_xr_c;
  logic signed [W-1:0] rd_xi_c;
  logic                eop_acc_c;
  logic                load_c;
  logic                cur_bank_c;
  bin_map_t            map_c;

  // On eop acceptance the next load already comes from the other bank
  always_comb begin
    eop_acc_c  = out_valid && out_ready && out_eop;
    load_c     = !out_valid || out_ready;
    cur_bank_c = eop_acc_c ? ~rd_bank : rd_bank;
    map_c      = bin_to_entry(32'(rd_bin), NFFT, NDATA);
  end

  sc_pingpong_buf #(
    .NDATA (NDATA),
    .W     (W)
  ) u_buf (
    .CLK       (CLK),
    .RST       (RST),
    .wr_valid  (in_valid),
    .wr_xr     (in_xr),
    .wr_xi     (in_xi),
    .wr_flush  (sym_flush),
    .rd_bank   (cur_bank_c),
    .rd_addr   (map_c.entry),
    .rd_xr_c   (rd_xr_c),
    .rd_xi_c   (rd_xi_c),
    .free      (eop_acc_c),
    .free_bank (rd_bank),
    .full      (full),
    .ovf       (ovf)
  );

  // rd_bin is the next bin to load; it wraps to 0 when bin NFFT-1 is loaded
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_bank   <= 1'b0;
      rd_bin    <= '0;
      out_valid <= 1'b0;
      out_xr    <= '0;
      out_xi    <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      if (eop_acc_c) begin
        rd_bank <= ~rd_bank;
      end
      if (load_c) begin
        if (full[cur_bank_c]) begin
          out_valid <= 1'b1;
          out_xr    <= map_c.is_data ? rd_xr_c : '0;
          out_xi    <= map_c.is_data ? rd_xi_c : '0;
          out_sop   <= (rd_bin == '0);
          out_eop   <= (rd_bin == BIN_W'(NFFT - 1));
          rd_bin    <= rd_bin + BIN_W'(1);
        end else begin
          out_valid <= 1'b0;
          out_xr    <= '0;
          out_xi    <= '0;
          out_sop   <= 1'b0;
          out_eop   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ofdm_sc_mapper.sv
// Directed-random bench for ofdm_sc_mapper against a symbol-queue reference model.
module tb_ofdm_sc_mapper;
  import ofdm_pkg::*;

  localparam int unsigned NFFT  = NFFT_DEF;
  localparam int unsigned NDATA = NDATA_DEF;
  localparam int unsigned W     = W_DEF;

  logic                CLK = 1'b0;
  logic                RST;
  logic                in_valid;
  logic signed [W-1:0] in_xr;
  logic signed [W-1:0] in_xi;
  logic                sym_flush;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_xr;
  logic signed [W-1:0] out_xi;
  logic                out_sop;
  logic                out_eop;
  logic                ovf;

  ofdm_sc_mapper #(.NFFT(NFFT), .NDATA(NDATA), .W(W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_xr(in_xr), .in_xi(in_xi),
    .sym_flush(sym_flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_xr(out_xr), .out_xi(out_xi), .out_sop(out_sop), .out_eop(out_eop),
    .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: partial symbol, completed symbols awaiting output
  int   pq_xr[$];
  int   pq_xi[$];
  int   fq_xr[$];
  int   fq_xi[$];
  int   nsym;
  int   mbin;
  int   syms_out;
  logic m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  // Forward mapping: data index k to its subcarrier, searched for bin b
  function automatic void exp_bin(input int b, output int xr, output int xi);
    int dst;
    xr = 0;
    xi = 0;
    for (int k = 0; k < int'(NDATA); k++) begin
      dst = (k < int'(NDATA) / 2) ? k + 1 : int'(NFFT) - int'(NDATA) + k;
      if (dst == b) begin
        xr = fq_xr[k];
        xi = fq_xi[k];
      end
    end
  endfunction

  task automatic model_reset();
    pq_xr.delete(); pq_xi.delete(); fq_xr.delete(); fq_xi.delete();
    nsym = 0; mbin = 0; m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_xr = '0; in_xi = '0; sym_flush = 1'b0; out_ready = 1'b0;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;
    model_reset();
  endtask

  // One clock: drive inputs, score the handshake, advance the model
  task automatic step(input logic v, input int xr, input int xi, input logic fl, input logic rdy);
    logic pv, psop, peop, acc;
    logic signed [W-1:0] pxr, pxi;
    int exr, exi;
    in_valid = v; in_xr = W'(xr); in_xi = W'(xi); sym_flush = fl; out_ready = rdy;
    pv = out_valid; pxr = out_xr; pxi = out_xi; psop = out_sop; peop = out_eop;
    acc = pv && rdy;
    chk("valid_needs_symbol", 32'(pv && nsym == 0), 32'(0));
    if (acc && nsym > 0) begin
      exp_bin(mbin, exr, exi);
      chk("bin_xr", 32'(pxr), 32'(exr));
      chk("bin_xi", 32'(pxi), 32'(exi));
      chk("bin_sop", 32'(psop), 32'(mbin == 0));
      chk("bin_eop", 32'(peop), 32'(mbin == int'(NFFT) - 1));
    end
    if (fl) begin
      pq_xr.delete(); pq_xi.delete();
    end else if (v) begin
      if (nsym == 2) begin
        m_ovf = 1'b1;
      end else begin
        pq_xr.push_back(xr); pq_xi.push_back(xi);
        if (pq_xr.size() == int'(NDATA)) begin
          foreach (pq_xr[i]) begin
            fq_xr.push_back(pq_xr[i]); fq_xi.push_back(pq_xi[i]);
          end
          pq_xr.delete(); pq_xi.delete();
          nsym++;
        end
      end
    end
    @(posedge CLK);
    #1;
    if (acc && nsym > 0) begin
      mbin++;
      if (mbin == int'(NFFT)) begin
        mbin = 0;
        for (int i = 0; i < int'(NDATA); i++) begin
          void'(fq_xr.pop_front()); void'(fq_xi.pop_front());
        end
        nsym--;
        syms_out++;
      end
    end
    if (pv && !rdy) begin
      chk("stall_valid", 32'(out_valid), 32'(pv));
      chk("stall_xr", 32'(out_xr), 32'(pxr));
      chk("stall_xi", 32'(out_xi), 32'(pxi));
      chk("stall_sop", 32'(out_sop), 32'(psop));
      chk("stall_eop", 32'(out_eop), 32'(peop));
    end
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic drain(input int budget, input logic rnd_ready);
    int n;
    n = 0;
    while ((nsym != 0 || out_valid) && n < budget) begin
      step(1'b0, 0, 0, 1'b0, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    chk("drain_done", 32'(nsym), 32'(0));
    chk("drain_idle", 32'(out_valid), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    syms_out = 0;
    model_reset();
    do_reset();

    // Reset state
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_xr", 32'(out_xr), 32'(0));
    chk("rst_xi", 32'(out_xi), 32'(0));
    chk("rst_sop", 32'(out_sop), 32'(0));
    chk("rst_eop", 32'(out_eop), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));

    // Single symbol, ramp data, latency to bin 0
    for (int k = 0; k < int'(NDATA); k++) step(1'b1, k, -k, 1'b0, 1'b1);
    chk("lat_not_yet", 32'(out_valid), 32'(0));
    step(1'b0, 0, 0, 1'b0, 1'b1);
    chk("lat_valid", 32'(out_valid), 32'(1));
    chk("lat_sop", 32'(out_sop), 32'(1));
    drain(200, 1'b0);
    chk("single_syms", 32'(syms_out), 32'(1));

    // Backpressure over two symbols
    syms_out = 0;
    for (int i = 0; i < 2 * int'(NDATA); i++)
      step(1'b1, rnd_s(), rnd_s(), 1'b0, 1'($urandom_range(0, 1)));
    drain(2000, 1'b1);
    chk("bp_syms", 32'(syms_out), 32'(2));

    // Overflow: third symbol dropped while output is stalled
    syms_out = 0;
    for (int i = 0; i < 3 * int'(NDATA); i++) step(1'b1, rnd_s(), rnd_s(), 1'b0, 1'b0);
    chk("ovf_sticky", 32'(ovf), 32'(1));
    drain(1000, 1'b0);
    chk("ovf_syms", 32'(syms_out), 32'(2));

    // Flush discards the partial symbol and beats a same-cycle sample
    do_reset();
    syms_out = 0;
    for (int i = 0; i < 20; i++) step(1'b1, rnd_s(), rnd_s(), 1'b0, 1'b1);
    step(1'b1, 99, 99, 1'b1, 1'b1);
    for (int i = 0; i < int'(NDATA); i++) step(1'b1, 7, 7, 1'b0, 1'b1);
    drain(300, 1'b0);
    chk("flush_syms", 32'(syms_out), 32'(1));
    chk("flush_ovf", 32'(ovf), 32'(0));

    // Write colliding with the eop acceptance that frees bank 0
    do_reset();
    for (int i = 0; i < 2 * int'(NDATA); i++) step(1'b1, rnd_s(), rnd_s(), 1'b0, 1'b0);
    chk("coll_pre_ovf", 32'(ovf), 32'(0));
    syms_out = 0;
    n = 0;
    while (!(out_valid && out_eop) && n < 300) begin
      step(1'b0, 0, 0, 1'b0, 1'b1);
      n++;
    end
    chk("coll_reached", 32'(out_valid && out_eop), 32'(1));
    step(1'b1, 111, -111, 1'b0, 1'b1);
    chk("coll_ovf", 32'(ovf), 32'(1));
    for (int i = 0; i < int'(NDATA); i++) step(1'b1, 200 + i, -200 - i, 1'b0, 1'b1);
    drain(500, 1'b0);
    chk("coll_syms", 32'(syms_out), 32'(3));

    // Asynchronous reset in the middle of a symbol
    do_reset();
    for (int i = 0; i < int'(NDATA); i++) step(1'b1, rnd_s(), rnd_s(), 1'b0, 1'b1);
    n = 0;
    while (!(out_valid && mbin == 30) && n < 200) begin
      step(1'b0, 0, 0, 1'b0, 1'b1);
      n++;
    end
    chk("mid_reached", 32'(out_valid && mbin == 30), 32'(1));
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_xr", 32'(out_xr), 32'(0));
    chk("mid_rst_xi", 32'(out_xi), 32'(0));
    chk("mid_rst_sop", 32'(out_sop), 32'(0));
    chk("mid_rst_eop", 32'(out_eop), 32'(0));
    do_reset();
    syms_out = 0;
    for (int i = 0; i < int'(NDATA); i++) step(1'b1, rnd_s(), rnd_s(), 1'b0, 1'b1);
    drain(300, 1'b0);
    chk("mid_syms", 32'(syms_out), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
